snow64_instr_reader: RTL and testbench
======================================

Name: snow64_instr_reader

Overview:
- Single-line instruction fetch buffer between the CPU fetch stage and the memory bus guard's instruction-read port.
- Holds one 256-bit line of eight 32-bit instructions and serves fetches from it.
- On a miss, issues a line read to the bus guard, waits for the data, then refills and serves the fetch.
- The flush input invalidates the buffer after stores into instruction space or after a mode change.

Parameters:
- ADDR_WIDTH, 64, CPU byte address width.
- LINE_WIDTH, 256, line width in bits; equals the LAR file data width.
- INSTR_WIDTH, 32, instruction width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_req  in  1  CPU requests the instruction at fetch_addr.
- fetch_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- fetch_ready  out  1  block can accept fetch_req this cycle.
- instr_valid  out  1  one-cycle pulse; instr holds the requested instruction.
- instr  out  INSTR_WIDTH  returned instruction.
- flush  in  1  invalidate the line and abandon any outstanding fill.
- bus_req  out  1  drives req_read_instr.req.
- bus_addr  out  ADDR_WIDTH  drives req_read_instr.addr; always line-aligned (bits [4:0] = 0).
- bus_cmd_accepted  in  1  from req_read_instr.cmd_accepted.
- bus_valid  in  1  from req_read_instr.valid.
- bus_data  in  LINE_WIDTH  from req_read_instr.data.

Behaviour:
- Reset values (async, rst_n low): state IDLE, line_valid 0, tag 0, line 0, bus_req 0, bus_addr 0, instr_valid 0, instr 0, drop_pending 0. fetch_ready is 1 out of reset.
- Line geometry: tag = addr[63:5]; word index = addr[4:2]; instruction word k = line[32k+31:32k], so word 0 is the LSBs.
- fetch_ready = (state == IDLE).
- fetch_req while fetch_ready is 0 is ignored and is not queued.
- IDLE, fetch_req, hit (line_valid && tag match):
  - instr_valid = 1 and instr = word on the next edge (latency 1).
  - State stays IDLE, so back-to-back hits sustain 1 instruction/cycle.
- IDLE, fetch_req, miss:
  - Latch the fetch address into pend_addr.
  - Set bus_req = 1 and bus_addr = {fetch_addr[63:5], 5'b0}; go to REQ.
- REQ:
  - Hold bus_req and bus_addr stable.
  - When bus_cmd_accepted is sampled high: bus_req <= 0, go to WAIT.
  - bus_req must drop on the edge following accept. The guard blocks re-acceptance only while cmd_accepted is high, so a late drop would cause a duplicate read.
- WAIT:
  - On bus_valid: line <= bus_data, tag <= pend_addr[63:5], line_valid <= 1.
  - Same edge: instr_valid <= 1, instr <= the word selected from bus_data by pend_addr[4:2]; go to IDLE.
  - Miss-to-instr_valid latency is the guard latency plus 2 edges; with an idle guard and synchronous BRAM this is 5 edges from fetch_req.
- bus_valid seen in IDLE or REQ: ignored; nothing can be outstanding there.
- flush:
  - line_valid <= 0 in every state.
  - In IDLE, flush takes priority over a simultaneous fetch_req; the fetch is dropped and instr_valid stays 0.
  - In REQ, drop bus_req immediately and return to IDLE.
    - If bus_cmd_accepted is high in the same cycle, the read is already accepted: set drop_pending and go to WAIT_DROP.
    - WAIT_DROP discards the next bus_valid, then returns to IDLE.
  - In WAIT, go to WAIT_DROP; the refill is discarded and no instr_valid is produced.
- Reset mid-operation: all state is cleared asynchronously.
  - A bus_valid for a fill issued before reset is ignored, because state is IDLE and the rule above applies.
  - The system resets the bus guard together with this block.
- Width rules: no arithmetic; tag compare is a 59-bit equality; word select is an 8:1 mux on 3 bits.

Decomposition:
- Shared package PkgSnow64InstrReader holds:
  - state enum (Idle, Req, Wait, WaitDrop),
  - Tag and WordIndex typedefs,
  - constants for word count (8) and line offset width (5).
- Reuse the bus guard package's PartialPortIn/Out_ReqRead structs for the bus side at the integration wrapper.
- Natural sub-module: snow64_instr_word_select, a combinational 8:1 word mux (line, index) -> instruction. It is used for both the hit path and the refill path.

Test Plan:
- Cold miss:
  - Stimulus: fetch_req at 0x1000_0024; the bus model asserts bus_cmd_accepted 1 cycle after bus_req and bus_valid 2 cycles later with data whose word k = 0xA000_0000+k.
  - Required: bus_addr = 0x1000_0020, exactly one accept, instr_valid with instr = 0xA000_0001.
- Hit stream:
  - Stimulus: after the fill above, fetch 0x1000_0020, 0x1000_0024, … through 0x1000_003C on consecutive cycles.
  - Required: 8 consecutive instr_valid pulses with 0xA000_0000 through 0xA000_0007 and no bus_req.
- Single-request check:
  - Stimulus: the bus model delays bus_cmd_accepted by 4 cycles.
  - Required: bus_req held for exactly those cycles, deasserted the edge after accept, and only one accept counted.
- Flush during WAIT:
  - Stimulus: miss to 0x2000_0000, then flush 1 cycle after accept.
  - Required: the bus_valid that follows produces no instr_valid, and a refetch of 0x2000_0000 issues a new bus_req.
- Flush with fetch in IDLE:
  - Stimulus: on a valid line, assert flush and fetch_req to a hitting address together.
  - Required: no instr_valid, and the next fetch to that address misses.
- Async reset in REQ:
  - Stimulus: pull rst_n low mid-cycle while in REQ, then release it.
  - Required: bus_req, instr_valid and fetch_ready take their reset values immediately; a stray bus_valid afterwards is ignored.

Source files
------------

// File: rtl/snow64_instr_reader_pkg.sv
// Shared types and line geometry for the single-line instruction fetch buffer.
package snow64_instr_reader_pkg;

  localparam int WORD_COUNT    = 8;
  localparam int LINE_OFFSET_W = 5;
  localparam int WORD_INDEX_W  = 3;
  localparam int TAG_W         = 64 - LINE_OFFSET_W;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    WAIT_DROP
  } state_t;

  typedef logic [TAG_W-1:0]        tag_t;
  typedef logic [WORD_INDEX_W-1:0] word_index_t;

endpackage

// File: rtl/snow64_instr_word_select.sv
// Combinational 8:1 instruction mux over a line; word 0 sits in the LSBs.
// Zero latency, no flow control.
module snow64_instr_word_select
  import snow64_instr_reader_pkg::*;
#(
  parameter int LINE_WIDTH  = 256,
  parameter int INSTR_WIDTH = 32
) (
  input  logic [LINE_WIDTH-1:0]  line,
  input  word_index_t            idx,
  output logic [INSTR_WIDTH-1:0] instr
);

  always_comb begin
    instr = '0;
    for (int k = 0; k < WORD_COUNT; k++) begin
      if (idx == word_index_t'(k)) instr = line[k*INSTR_WIDTH +: INSTR_WIDTH];
    end
  end

endmodule

// File: rtl/snow64_instr_reader.sv
// Single-line instruction buffer: hits return in 1 edge, misses fetch a line over the bus guard.
// fetch_ready is low while a fill is outstanding; fetches offered then are dropped, not queued.
module snow64_instr_reader
  import snow64_instr_reader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int LINE_WIDTH  = 256,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic                   fetch_ready,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  input  logic                   flush,
  output logic                   bus_req,
  output logic [ADDR_WIDTH-1:0]  bus_addr,
  input  logic                   bus_cmd_accepted,
  input  logic                   bus_valid,
  input  logic [LINE_WIDTH-1:0]  bus_data
);

  localparam int LINE_TAG_W = ADDR_WIDTH - LINE_OFFSET_W;

  state_t                  state;
  logic                    line_valid;
  logic [LINE_TAG_W-1:0]   tag;
  logic [LINE_WIDTH-1:0]   line;
  logic [ADDR_WIDTH-1:2]   pend_addr;
  logic                    drop_pending;

  logic                    hit;
  logic [INSTR_WIDTH-1:0]  hit_word;
  logic [INSTR_WIDTH-1:0]  fill_word;
  logic                    unused_byte_offset;

  // Instructions are word aligned; the byte offset carries no information.
  assign unused_byte_offset = ^fetch_addr[1:0];

  assign fetch_ready = (state == IDLE);
  assign hit = line_valid && (tag == fetch_addr[ADDR_WIDTH-1:LINE_OFFSET_W]);

  snow64_instr_word_select #(
    .LINE_WIDTH  (LINE_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_hit_sel (
    .line  (line),
    .idx   (fetch_addr[4:2]),
    .instr (hit_word)
  );

  snow64_instr_word_select #(
    .LINE_WIDTH  (LINE_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_fill_sel (
    .line  (bus_data),
    .idx   (pend_addr[4:2]),
    .instr (fill_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      line_valid   <= 1'b0;
      tag          <= '0;
      line         <= '0;
      pend_addr    <= '0;
      drop_pending <= 1'b0;
      bus_req      <= 1'b0;
      bus_addr     <= '0;
      instr_valid  <= 1'b0;
      instr        <= '0;
    end else begin
      instr_valid <= 1'b0;
      if (flush) line_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!flush && fetch_req) begin
            if (hit) begin
              instr_valid <= 1'b1;
              instr       <= hit_word;
            end else begin
              pend_addr <= fetch_addr[ADDR_WIDTH-1:2];
              bus_req   <= 1'b1;
              bus_addr  <= {fetch_addr[ADDR_WIDTH-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
              state     <= REQ;
            end
          end
        end

        // The guard only blocks re-acceptance while cmd_accepted is high,
        // so bus_req must fall on the very edge that samples the accept.
        REQ: begin
          if (flush) begin
            bus_req <= 1'b0;
            if (bus_cmd_accepted) begin
              drop_pending <= 1'b1;
              state        <= WAIT_DROP;
            end else begin
              state <= IDLE;
            end
          end else if (bus_cmd_accepted) begin
            bus_req <= 1'b0;
            state   <= WAIT;
          end
        end

        WAIT: begin
          if (flush) begin
            // A response arriving on the flush edge is already consumed here.
            if (bus_valid) begin
              state <= IDLE;
            end else begin
              drop_pending <= 1'b1;
              state        <= WAIT_DROP;
            end
          end else if (bus_valid) begin
            line        <= bus_data;
            tag         <= pend_addr[ADDR_WIDTH-1:LINE_OFFSET_W];
            line_valid  <= 1'b1;
            instr_valid <= 1'b1;
            instr       <= fill_word;
            state       <= IDLE;
          end
        end

        WAIT_DROP: begin
          if (bus_valid || !drop_pending) begin
            drop_pending <= 1'b0;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_instr_reader.sv
// Directed bench for snow64_instr_reader: inputs driven and outputs sampled on the falling edge.
module tb_snow64_instr_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fetch_req;
  logic [63:0]  fetch_addr;
  logic         fetch_ready;
  logic         instr_valid;
  logic [31:0]  instr;
  logic         flush;
  logic         bus_req;
  logic [63:0]  bus_addr;
  logic         bus_cmd_accepted;
  logic         bus_valid;
  logic [255:0] bus_data;

  int n_vec = 0;
  int n_err = 0;
  int req_cnt = 0;
  int acc_cnt = 0;

  always #5 clk = ~clk;

  snow64_instr_reader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_req        (fetch_req),
    .fetch_addr       (fetch_addr),
    .fetch_ready      (fetch_ready),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .flush            (flush),
    .bus_req          (bus_req),
    .bus_addr         (bus_addr),
    .bus_cmd_accepted (bus_cmd_accepted),
    .bus_valid        (bus_valid),
    .bus_data         (bus_data)
  );

  // Bus-side observer: request cycles and accepted commands as the guard sees them.
  always @(posedge clk) begin
    if (bus_req) req_cnt++;
    if (bus_req && bus_cmd_accepted) acc_cnt++;
  end

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  // Miss sequence: accept after acc_dly extra cycles, data one idle cycle later.
  task automatic fetch_miss(input logic [63:0] addr, input int acc_dly,
                            input logic [31:0] base, input logic [31:0] exp_instr,
                            input logic [63:0] exp_addr, input string tag);
    int acc0;
    int req0;
    acc0       = acc_cnt;
    req0       = req_cnt;
    fetch_req  = 1'b1;
    fetch_addr = addr;
    cyc();
    fetch_req = 1'b0;
    chk_val({tag, "_req"}, 64'(bus_req), 64'd1);
    chk_val({tag, "_addr"}, bus_addr, exp_addr);
    chk_val({tag, "_busy"}, 64'(fetch_ready), 64'd0);
    for (int i = 0; i < acc_dly; i++) begin
      cyc();
      chk_val({tag, "_req_hold"}, 64'(bus_req), 64'd1);
    end
    bus_cmd_accepted = 1'b1;
    cyc();
    bus_cmd_accepted = 1'b0;
    chk_val({tag, "_req_drop"}, 64'(bus_req), 64'd0);
    cyc();
    chk_val({tag, "_no_early_vld"}, 64'(instr_valid), 64'd0);
    bus_valid = 1'b1;
    bus_data  = make_line(base);
    cyc();
    bus_valid = 1'b0;
    chk_val({tag, "_vld"}, 64'(instr_valid), 64'd1);
    chk_val({tag, "_instr"}, 64'(instr), 64'(exp_instr));
    chk_val({tag, "_accepts"}, 64'(acc_cnt - acc0), 64'd1);
    chk_val({tag, "_req_cycles"}, 64'(req_cnt - req0), 64'(acc_dly + 1));
  endtask

  initial begin
    int req0;
    rst_n            = 1'b0;
    fetch_req        = 1'b0;
    fetch_addr       = '0;
    flush            = 1'b0;
    bus_cmd_accepted = 1'b0;
    bus_valid        = 1'b0;
    bus_data         = '0;
    cyc();
    cyc();
    chk_val("rst_ready", 64'(fetch_ready), 64'd1);
    chk_val("rst_bus_req", 64'(bus_req), 64'd0);
    chk_val("rst_bus_addr", bus_addr, 64'd0);
    chk_val("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk_val("rst_instr", 64'(instr), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Cold miss.
    fetch_miss(64'h1000_0024, 0, 32'hA000_0000, 32'hA000_0001, 64'h1000_0020, "cold");
    cyc();
    chk_val("cold_idle", 64'(fetch_ready), 64'd1);

    // Hit stream over the whole line at one instruction per cycle.
    req0      = req_cnt;
    fetch_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      fetch_addr = 64'h1000_0020 + 64'(4 * k);
      cyc();
      chk_val($sformatf("hit%0d_vld", k), 64'(instr_valid), 64'd1);
      chk_val($sformatf("hit%0d_instr", k), 64'(instr), 64'hA000_0000 + 64'(k));
    end
    fetch_req = 1'b0;
    cyc();
    chk_val("hit_end_vld", 64'(instr_valid), 64'd0);
    chk_val("hit_no_bus_req", 64'(req_cnt - req0), 64'd0);

    // Delayed accept: request held 4 extra cycles, single accept.
    fetch_miss(64'h3000_0008, 4, 32'hC000_0000, 32'hC000_0002, 64'h3000_0000, "slow");
    cyc();

    // Flush one cycle after accept: refill discarded.
    fetch_req  = 1'b1;
    fetch_addr = 64'h2000_0000;
    cyc();
    fetch_req        = 1'b0;
    bus_cmd_accepted = 1'b1;
    cyc();
    bus_cmd_accepted = 1'b0;
    flush            = 1'b1;
    cyc();
    flush = 1'b0;
    chk_val("fw_busy", 64'(fetch_ready), 64'd0);
    bus_valid = 1'b1;
    bus_data  = make_line(32'hB000_0000);
    cyc();
    bus_valid = 1'b0;
    chk_val("fw_no_vld", 64'(instr_valid), 64'd0);
    chk_val("fw_idle", 64'(fetch_ready), 64'd1);
    fetch_miss(64'h2000_0000, 0, 32'hB100_0000, 32'hB100_0000, 64'h2000_0000, "refetch");
    cyc();

    // Flush together with a hitting fetch in IDLE.
    fetch_req  = 1'b1;
    fetch_addr = 64'h2000_0004;
    flush      = 1'b1;
    cyc();
    fetch_req = 1'b0;
    flush     = 1'b0;
    chk_val("fi_no_vld", 64'(instr_valid), 64'd0);
    chk_val("fi_no_req", 64'(bus_req), 64'd0);
    fetch_miss(64'h2000_0004, 0, 32'hD000_0000, 32'hD000_0001, 64'h2000_0000, "fi_miss");
    cyc();

    // Flush in REQ on the accept cycle: the in-flight response must be swallowed.
    fetch_req  = 1'b1;
    fetch_addr = 64'h5000_0010;
    cyc();
    fetch_req        = 1'b0;
    flush            = 1'b1;
    bus_cmd_accepted = 1'b1;
    cyc();
    flush            = 1'b0;
    bus_cmd_accepted = 1'b0;
    chk_val("fra_req_drop", 64'(bus_req), 64'd0);
    chk_val("fra_busy", 64'(fetch_ready), 64'd0);
    bus_valid = 1'b1;
    cyc();
    bus_valid = 1'b0;
    chk_val("fra_no_vld", 64'(instr_valid), 64'd0);
    chk_val("fra_idle", 64'(fetch_ready), 64'd1);

    // Async reset while in REQ.
    fetch_req  = 1'b1;
    fetch_addr = 64'h4000_0000;
    cyc();
    fetch_req = 1'b0;
    chk_val("ar_req_before", 64'(bus_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_val("ar_req", 64'(bus_req), 64'd0);
    chk_val("ar_ready", 64'(fetch_ready), 64'd1);
    chk_val("ar_vld", 64'(instr_valid), 64'd0);
    chk_val("ar_addr", bus_addr, 64'd0);
    cyc();
    rst_n     = 1'b1;
    bus_valid = 1'b1;
    bus_data  = make_line(32'hF000_0000);
    cyc();
    bus_valid = 1'b0;
    chk_val("ar_stray_vld", 64'(instr_valid), 64'd0);
    chk_val("ar_stray_ready", 64'(fetch_ready), 64'd1);
    chk_val("ar_stray_req", 64'(bus_req), 64'd0);
    fetch_miss(64'h2000_0004, 0, 32'hE000_0000, 32'hE000_0001, 64'h2000_0000, "ar_miss");
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
